// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_muldiv_occupancy.sv
// rtl/hazard_ctrl_muldiv_occupancy.sv - mul/div unit occupancy FSM and down-counter
module muldiv_occupancy
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - IF/ID stall/flush control; HAZARD_MULDIV_EN builds the mul/div interlock
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IDRs,
    input  logic [4:0] IDRt,
    input  logic       IDUsesRt,
    input  logic [4:0] IDEXRt,
    input  logic       IDEXMemRd,
    input  logic       IDIsMulDiv,
    input  logic       IDIsDiv,
    input  logic       IDReadsHiLo,
    input  logic       BranchTaken,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       IDEXFlush,
    output logic       MulDivStart,
    output logic       MulDivBusy
);

    logic lu_stall;
    logic md_stall;
    logic stall;

    assign lu_stall = IDEXMemRd && (IDEXRt != REG_ZERO) &&
                      ((IDEXRt == IDRs) || (IDUsesRt && (IDEXRt == IDRt)));

`ifdef HAZARD_MULDIV_EN
    assign md_stall = MulDivBusy && (IDReadsHiLo || IDIsMulDiv);

    muldiv_occupancy #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_occupancy (
        .clk    (clk),
        .reset  (reset),
        .start  (MulDivStart),
        .is_div (IDIsDiv),
        .busy   (MulDivBusy)
    );
`else
    localparam int unused_cfg = MUL_CYCLES + DIV_CYCLES + CNT_W;
    logic unused_in;
    assign unused_in  = &{1'b0, clk, IDIsDiv, IDReadsHiLo};
    assign md_stall   = 1'b0;
    assign MulDivBusy = 1'b0;
`endif

    // Reset forces the free-running "advance" encoding so the PC is not frozen.
    assign stall = !reset && (lu_stall || md_stall);

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        MulDivStart = 1'b0;
        if (!reset) begin
            if (stall) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end else if (BranchTaken) begin
                IFIDFlush = 1'b1;
            end
            MulDivStart = IDIsMulDiv && !stall;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IDRs, IDRt, IDEXRt;
    logic       IDUsesRt, IDEXMemRd, IDIsMulDiv, IDIsDiv, IDReadsHiLo, BranchTaken;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MulDivStart, MulDivBusy;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    int busy_left = 0;

`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDEXRt(IDEXRt), .IDEXMemRd(IDEXMemRd),
        .IDIsMulDiv(IDIsMulDiv), .IDIsDiv(IDIsDiv), .IDReadsHiLo(IDReadsHiLo),
        .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .MulDivStart(MulDivStart), .MulDivBusy(MulDivBusy)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_lu();
        return IDEXMemRd && IDEXRt != 5'd0 &&
               (IDEXRt == IDRs || (IDUsesRt && IDEXRt == IDRt));
    endfunction

    function automatic bit m_stall();
        bit md;
        md = MD_EN && busy_left > 0 && (IDReadsHiLo || IDIsMulDiv);
        return !reset && (m_lu() || md);
    endfunction

    function automatic bit m_start();
        return !reset && IDIsMulDiv && !m_stall();
    endfunction

    // Remaining busy cycles of the unit, from the issue rule alone.
    always @(posedge clk) begin
        if (reset) busy_left <= 0;
        else if (!MD_EN) busy_left <= 0;
        else if (busy_left > 0) busy_left <= busy_left - 1;
        else if (m_start()) busy_left <= IDIsDiv ? 32 : 4;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("m_pcwrite",   PCWrite,     !m_stall());
            check("m_ifidwrite", IFIDWrite,   !m_stall());
            check("m_idexflush", IDEXFlush,   m_stall());
            check("m_ifidflush", IFIDFlush,   !reset && !m_stall() && BranchTaken);
            check("m_start",     MulDivStart, m_start());
            check("m_busy",      MulDivBusy,  busy_left > 0);
        end
    end

    task automatic clear_in();
        IDRs = 5'd0; IDRt = 5'd0; IDEXRt = 5'd0; IDUsesRt = 0; IDEXMemRd = 0;
        IDIsMulDiv = 0; IDIsDiv = 0; IDReadsHiLo = 0; BranchTaken = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int held;
        reset = 1'b1;
        clear_in();
        IDIsMulDiv = 1'b1;
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("rst_pcwrite", PCWrite, 1'b1);
        check("rst_start",   MulDivStart, 1'b0);
        check("rst_busy",    MulDivBusy, 1'b0);
        next_cycle();
        reset = 1'b0;
        clear_in();

        // load-use on rs
        IDEXMemRd = 1; IDEXRt = 5'd8; IDRs = 5'd8;
        @(negedge clk);
        check("lu_rs_pcwrite", PCWrite, 1'b0);
        check("lu_rs_ifidw",   IFIDWrite, 1'b0);
        check("lu_rs_idexfl",  IDEXFlush, 1'b1);
        next_cycle();
        clear_in();
        @(negedge clk);
        check("lu_rs_after", PCWrite, 1'b1);
        next_cycle();
        IDEXMemRd = 1; IDEXRt = 5'd0; IDRs = 5'd0;
        @(negedge clk);
        check("lu_r0_nostall", PCWrite, 1'b1);
        next_cycle();

        // load-use on rt
        clear_in();
        IDEXMemRd = 1; IDEXRt = 5'd9; IDRt = 5'd9; IDRs = 5'd3; IDUsesRt = 0;
        @(negedge clk);
        check("lu_rt_unused", PCWrite, 1'b1);
        next_cycle();
        IDUsesRt = 1;
        @(negedge clk);
        check("lu_rt_used", PCWrite, 1'b0);
        next_cycle();

        // branch vs stall
        clear_in();
        IDEXMemRd = 1; IDEXRt = 5'd8; IDRs = 5'd8; BranchTaken = 1;
        @(negedge clk);
        check("br_lu_ifidfl", IFIDFlush, 1'b0);
        check("br_lu_idexfl", IDEXFlush, 1'b1);
        next_cycle();
        clear_in();
        BranchTaken = 1;
        @(negedge clk);
        check("br_alone_ifidfl", IFIDFlush, 1'b1);
        check("br_alone_idexfl", IDEXFlush, 1'b0);
        next_cycle();

        // multiply then mfhi
        clear_in();
        IDIsMulDiv = 1;
        @(negedge clk);
        check("mult_start", MulDivStart, 1'b1);
        next_cycle();
        clear_in();
        IDReadsHiLo = 1;
        if (MD_EN) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("mfhi_held", PCWrite, 1'b0);
                check("mfhi_busy", MulDivBusy, 1'b1);
                next_cycle();
            end
        end
        @(negedge clk);
        check("mfhi_adv", PCWrite, 1'b1);
        check("mfhi_notbusy", MulDivBusy, 1'b0);
        next_cycle();

        // branch together with mult issue
        clear_in();
        IDIsMulDiv = 1; BranchTaken = 1;
        @(negedge clk);
        check("brmul_start", MulDivStart, 1'b1);
        check("brmul_ifidfl", IFIDFlush, 1'b1);
        next_cycle();
        clear_in();
        for (int i = 0; i < 5; i++) next_cycle();

        // divide then back-to-back mult
        IDIsMulDiv = 1; IDIsDiv = 1;
        @(negedge clk);
        check("div_start", MulDivStart, 1'b1);
        next_cycle();
        IDIsDiv = 0;
        held = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MulDivStart) break;
            held++;
            next_cycle();
        end
        check_int("div_hold_cycles", held, MD_EN ? 32 : 0);
        next_cycle();
        clear_in();
        for (int i = 0; i < 5; i++) next_cycle();

        // reset mid-divide
        IDIsMulDiv = 1; IDIsDiv = 1;
        next_cycle();
        clear_in();
        for (int i = 0; i < 4; i++) next_cycle();
        reset = 1; IDReadsHiLo = 1;
        @(negedge clk);
        check("rstmid_pcwrite", PCWrite, 1'b1);
        next_cycle();
        reset = 0;
        @(negedge clk);
        check("rstmid_busy", MulDivBusy, 1'b0);
        check("rstmid_mfhi_adv", PCWrite, 1'b1);
        next_cycle();
        clear_in();
        next_cycle();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
